// File: rtl/tx_ip_checksum_insert.sv
// tx_ip_checksum_insert
//   Computes the IPv4 header checksum from the first beat of each outgoing
//   frame and writes it into bytes 24-25. Every other byte, tkeep and tlast
//   pass through unchanged.
//
// Ports
//   tx_axis_aclk, tx_axis_aresetn : clock, synchronous active-low reset
//   csum_enable                   : 1 = insert checksum (sampled on first beat)
//   s_axis_*                      : frame from headers prepend (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_*                      : frame to CMAC (tdata/tkeep/tvalid/tlast/tready)
//   stat_frames_csum              : frames with checksum inserted (32-bit, wraps)
//   stat_frames_bypass            : frames passed unmodified (32-bit, wraps)
//
// Optional build macro: TX_MIN_FRAME_PAD_EN (needs DATA_WIDTH >= 480)
//   Single-beat frames with fewer than 60 valid bytes are padded with zero
//   bytes up to 60 bytes (tkeep bytes 0..59 set).

// Purpose: IPv4 header checksum insert on the AXIS TX path.
// Latency: 2 cycles accept-to-output, 1 beat/cycle.
// Backpressure: both stages hold while output stalls; s_axis_tready = !m_axis_tvalid || m_axis_tready.
module tx_ip_checksum_insert #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                      tx_axis_aclk,
    input  logic                      tx_axis_aresetn,
    input  logic                      csum_enable,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [31:0]               stat_frames_csum,
    output logic [31:0]               stat_frames_bypass
);

    localparam int KW = DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic w_adv;
    logic w_acc;

    // Output register
    logic                  r_m_vld;
    logic [DATA_WIDTH-1:0] r_m_dat;
    logic [KW-1:0]         r_m_keep;
    logic                  r_m_last;
    logic                  r_m_first;
    logic                  r_m_qual;

    // Only the output stage feeds back into ready, so there is no
    // combinational path from s_axis_tvalid to s_axis_tready.
    assign w_adv         = !r_m_vld || m_axis_tready;
    assign w_acc         = s_axis_tvalid && w_adv;
    assign s_axis_tready = w_adv;

    // ------------------------------------------------------------------
    // Stage 1: first-beat qualification and partial checksum sums
    // ------------------------------------------------------------------
    logic                  r_sof;
    logic                  r_s1_vld;
    logic [DATA_WIDTH-1:0] r_s1_dat;
    logic [KW-1:0]         r_s1_keep;
    logic                  r_s1_last;
    logic                  r_s1_first;
    logic                  r_s1_qual;
    logic [18:0]           r_s1_sum_lo;
    logic [18:0]           r_s1_sum_hi;

    logic [15:0]           w_word [10];
    logic [18:0]           w_sum_lo;
    logic [18:0]           w_sum_hi;
    logic                  w_qual;

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            // Word 5 is the checksum field itself; upstream normally zeroes it
            // but a stale value must not leak into the sum.
            if (i == 5) begin
                w_word[i] = 16'h0000;
            end else begin
                w_word[i] = {s_axis_tdata[8*(14+2*i) +: 8], s_axis_tdata[8*(15+2*i) +: 8]};
            end
        end
        w_sum_lo = 19'(w_word[0]) + 19'(w_word[1]) + 19'(w_word[2])
                 + 19'(w_word[3]) + 19'(w_word[4]);
        w_sum_hi = 19'(w_word[5]) + 19'(w_word[6]) + 19'(w_word[7])
                 + 19'(w_word[8]) + 19'(w_word[9]);
    end

    assign w_qual = r_sof && csum_enable
                 && (s_axis_tdata[8*12 +: 8] == 8'h08)
                 && (s_axis_tdata[8*13 +: 8] == 8'h00)
                 && (s_axis_tdata[8*14 +: 8] == 8'h45)
                 && (&s_axis_tkeep[33:0]);

`ifdef TX_MIN_FRAME_PAD_EN
    localparam int CW = $clog2(KW + 1);
    logic [CW-1:0] w_keep_cnt;
    logic          w_pad;
    logic          r_s1_pad;

    always_comb begin
        w_keep_cnt = '0;
        for (int k = 0; k < KW; k++) begin
            w_keep_cnt = w_keep_cnt + CW'(s_axis_tkeep[k]);
        end
    end

    // Only whole frames held in one beat are padded; multi-beat frames are
    // already longer than the minimum.
    assign w_pad = r_sof && s_axis_tlast && (int'(w_keep_cnt) < 60);
`endif

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            r_sof       <= 1'b1;
            r_s1_vld    <= 1'b0;
            r_s1_dat    <= '0;
            r_s1_keep   <= '0;
            r_s1_last   <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_qual   <= 1'b0;
            r_s1_sum_lo <= '0;
            r_s1_sum_hi <= '0;
`ifdef TX_MIN_FRAME_PAD_EN
            r_s1_pad    <= 1'b0;
`endif
        end else begin
            if (w_acc) begin
                r_sof <= s_axis_tlast;
            end
            if (w_adv) begin
                r_s1_vld    <= s_axis_tvalid;
                r_s1_dat    <= s_axis_tdata;
                r_s1_keep   <= s_axis_tkeep;
                r_s1_last   <= s_axis_tlast;
                r_s1_first  <= r_sof;
                r_s1_qual   <= w_qual;
                r_s1_sum_lo <= w_sum_lo;
                r_s1_sum_hi <= w_sum_hi;
`ifdef TX_MIN_FRAME_PAD_EN
                r_s1_pad    <= w_pad;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: fold, invert, patch bytes 24-25
    // ------------------------------------------------------------------
    logic [19:0]           w_sum20;
    logic [16:0]           w_fold1;
    logic [15:0]           w_fold2;
    logic [15:0]           w_csum;
    logic [DATA_WIDTH-1:0] w_s2_dat;
    logic [KW-1:0]         w_s2_keep;

    // Two folds are enough: after the first, the value is at most 0x1000E,
    // so the second fold cannot carry out again.
    assign w_sum20 = 20'(r_s1_sum_lo) + 20'(r_s1_sum_hi);
    assign w_fold1 = 17'(w_sum20[15:0]) + 17'(w_sum20[19:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    assign w_csum  = ~w_fold2;

    always_comb begin
        w_s2_dat  = r_s1_dat;
        w_s2_keep = r_s1_keep;
`ifdef TX_MIN_FRAME_PAD_EN
        if (r_s1_pad) begin
            for (int k = 0; k < 60; k++) begin
                if (!r_s1_keep[k]) begin
                    w_s2_dat[8*k +: 8] = 8'h00;
                    w_s2_keep[k]       = 1'b1;
                end
            end
        end
`endif
        // A qualified beat has bytes 0..33 valid, so padding never overlaps the patch.
        if (r_s1_qual) begin
            w_s2_dat[8*24 +: 8] = w_csum[15:8];
            w_s2_dat[8*25 +: 8] = w_csum[7:0];
        end
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            r_m_vld   <= 1'b0;
            r_m_dat   <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_first <= 1'b0;
            r_m_qual  <= 1'b0;
        end else if (w_adv) begin
            r_m_vld   <= r_s1_vld;
            r_m_dat   <= w_s2_dat;
            r_m_keep  <= w_s2_keep;
            r_m_last  <= r_s1_last;
            r_m_first <= r_s1_first;
            r_m_qual  <= r_s1_qual;
        end
    end

    assign m_axis_tvalid = r_m_vld;
    assign m_axis_tdata  = r_m_dat;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tlast  = r_m_last;

    // ------------------------------------------------------------------
    // Statistics: counted once per frame when its first beat leaves
    // ------------------------------------------------------------------
    logic [31:0] r_stat_csum;
    logic [31:0] r_stat_bypass;

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            r_stat_csum   <= '0;
            r_stat_bypass <= '0;
        end else if (r_m_vld && m_axis_tready && r_m_first) begin
            if (r_m_qual) begin
                r_stat_csum   <= r_stat_csum + 32'd1;
            end else begin
                r_stat_bypass <= r_stat_bypass + 32'd1;
            end
        end
    end

    assign stat_frames_csum   = r_stat_csum;
    assign stat_frames_bypass = r_stat_bypass;

endmodule

// File: doc/tx_ip_checksum_insert.md
Name: tx_ip_checksum_insert

Overview:
- Fills the IPv4 header checksum field of each outgoing frame. Sits between tx_headers_prepend and the CMAC TX port inside ethernet_tx.
- tx_headers_prepend emits frames with the checksum field zeroed. This block computes the RFC 791 ones'-complement checksum from the first beat, patches bytes 24-25 and forwards the frame.
- 2-stage registered pipeline, full throughput.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits. Multiple of 8, at least 272, so the 34-byte ETH+IP header fits entirely in the first beat.

Ports:
- tx_axis_aclk  in  1  clock
- tx_axis_aresetn  in  1  synchronous active-low reset
- csum_enable  in  1  1 = insert checksum; sampled on each frame's first beat
- s_axis_tdata  in  DATA_WIDTH  frame from headers prepend; byte k at tdata[8k+7:8k]
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  frame to CMAC
- m_axis_tkeep  out  DATA_WIDTH/8  byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last beat
- m_axis_tready  in  1  CMAC ready
- stat_frames_csum  out  32  frames with checksum inserted
- stat_frames_bypass  out  32  frames passed unmodified

Behaviour:
- Reset (tx_axis_aresetn low at a clock edge):
  - both stage valids clear; m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0;
  - sof flag=1; both counters=0.
  - Reset mid-frame discards in-flight beats. The next accepted beat is treated as a first beat.
- Pipeline control:
  - adv = !m_axis_tvalid || m_axis_tready; s_axis_tready = adv.
  - s_axis_tready has a combinational path from m_axis_tready only; no tvalid->tready path.
  - When adv=1, stage1 loads the input beat and stage2 loads stage1.
  - When adv=0, both stages hold. Output holds stable while tvalid=1 and tready=0 (AXIS rule).
- Latency: 2 cycles from input accept to m_axis_tvalid, no stalls. Throughput: 1 beat/cycle.
- sof tracking: sof=1 after reset and after any accepted beat with tlast=1. It clears on any accepted beat with tlast=0.
  - A single-beat frame (sof=1 and tlast=1) is a valid first beat.
- Frame qualification, on the first beat only:
  - csum_enable=1;
  - bytes 12,13 == 0x08,0x00 (EtherType IPv4);
  - byte 14 == 0x45 (IPv4, IHL=5);
  - tkeep bytes 0..33 all set.
  - Qualified frames are patched; all others pass bit-exact as bypass.
- Checksum arithmetic:
  - word i (i=0..9) = {byte[14+2i], byte[15+2i]}, with word 5 (bytes 24,25) forced to 0 whatever its input value.
  - Stage1 registers two partial sums: words 0-4 and words 5-9, 19 bits each.
  - Stage2 adds them (20 bits), folds carries twice: s=(s[15:0]+s[19:16]), then again. Result is inverted to 16 bits.
  - Stage2 writes byte 24 = csum[15:8], byte 25 = csum[7:0]. All other bytes, tkeep and tlast are unchanged.
- Non-first beats always pass unmodified.
- Counters: increment at the first-beat output handshake (m_axis_tvalid && m_axis_tready) by frame classification. 32-bit, wrap 0xFFFFFFFF -> 0.
- Backpressure: a stall of any length loses no data; a beat is accepted and emitted exactly once.

Optional Feature:
- Macro TX_MIN_FRAME_PAD_EN, requires DATA_WIDTH >= 480.
- Defined:
  - A single-beat frame (sof and tlast on the same beat) with fewer than 60 tkeep bits set gets tkeep extended to bytes 0..59 contiguous.
  - Padding bytes are forced to 0x00 in stage2.
  - Checksum is unaffected.
  - Multi-beat frames are untouched.
- Undefined: tkeep/tdata pass as described above; no padding logic is instantiated.

Test Plan:
- Header bytes 14..33 = 45 00 00 73 00 00 40 00 40 11 00 00 c0 a8 00 01 c0 a8 00 c7, EtherType 0800, csum_enable=1 -> bytes 24,25 = b8 61; stat_frames_csum=1; output appears 2 cycles after accept.
- Same frame with bytes 24,25 preset to ff ff -> output still b8 61.
- EtherType 86dd (IPv6) frame, or csum_enable=0 -> output bit-identical to input; stat_frames_bypass increments.
- 3-beat frame; m_axis_tready toggled 1,0,0,1,0,1 during transfer -> all 3 beats emitted in order, no duplicates; first beat patched; tlast only on beat 3.
- Back-to-back frames, tvalid held high, m_axis_tready=1 -> 1 beat/cycle with no bubbles; sof correct for each frame.
- Reset asserted mid-frame, then new frame -> no stale beats out; new frame's first beat patched; counters restart at 0.
- With TX_MIN_FRAME_PAD_EN, 42-byte single-beat frame -> tkeep = 60 ones, bytes 42..59 = 00.
